// File: rtl/class_score_accumulator_if.sv
// class_score_accumulator_if: activation/weight stream and score result bundle
//   start, in_valid, in_data, w_data : driven by the producer (master)
//   in_ready, busy, scores_valid, scores : driven by the accumulator (slave)
interface class_score_accumulator_if #(
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int OUT_W = 11
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_W-1:0]      in_data;
    logic [8*W_W-1:0]     w_data;
    logic                 busy;
    logic                 scores_valid;
    logic [8*OUT_W-1:0]   scores;
    modport master (
        output start, in_valid, in_data, w_data,
        input  in_ready, busy, scores_valid, scores
    );
    modport slave (
        input  start, in_valid, in_data, w_data,
        output in_ready, busy, scores_valid, scores
    );
endinterface

// File: rtl/class_score_accumulator.sv
// class_score_accumulator: dense output layer, 8-class multiply-accumulate with scaled/clamped scores
//   Clk      : rising-edge clock
//   Reset_n  : asynchronous active-low reset
//   bus      : slave side of class_score_accumulator_if
//              start/in_valid/in_data/w_data in; in_ready/busy/scores_valid/scores out
//   Macro SCORE_SAT_EN: defined -> scores saturate to the signed OUT_W range,
//                       undefined -> scores keep the low OUT_W bits (wrap).
module class_score_accumulator #(
    parameter int N_IN  = 64,
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 24,
    parameter int SHIFT = 4,
    parameter int OUT_W = 11
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    class_score_accumulator_if.slave bus
);
    localparam int CW = $clog2(N_IN);
    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;
    state_t                      state, state_nx;
    logic [CW-1:0]               cnt;
    logic signed [ACC_W-1:0]     acc [8];
    logic signed [IN_W+W_W-1:0]  prod [8];
    logic [8*OUT_W-1:0]          scores_q, scores_nx;
    logic                        fire, last, clr;
    assign fire = bus.in_valid && bus.in_ready;
    assign last = cnt == CW'(N_IN - 1);
    // start only restarts from an idle or finished result, never mid-accumulation
    assign clr  = bus.start && (state == IDLE || state == DONE);
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE  ? (bus.start ? ACCUM : IDLE) :
                   state == ACCUM ? (fire && last ? FINAL : ACCUM) :
                   state == FINAL ? DONE :
                                    (bus.start ? ACCUM : DONE);
    end
    // scores_valid is a pure decode of the registered state, so it cannot glitch
    always_comb begin
        bus.in_ready     = state == ACCUM;
        bus.busy         = state == ACCUM || state == FINAL;
        bus.scores_valid = state == DONE;
        bus.scores       = scores_q;
    end
    always_comb begin
        for (int k = 0; k < 8; k++)
            prod[k] = $signed(bus.in_data) * $signed(bus.w_data[k*W_W +: W_W]);
    end
`ifdef SCORE_SAT_EN
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);
    logic signed [ACC_W-1:0] sh [8];
    always_comb begin
        scores_nx = '0;
        for (int k = 0; k < 8; k++) begin
            sh[k] = acc[k] >>> SHIFT;
            scores_nx[k*OUT_W +: OUT_W] = sh[k] > SMAX ? SMAX[OUT_W-1:0] :
                                          sh[k] < SMIN ? SMIN[OUT_W-1:0] :
                                                         sh[k][OUT_W-1:0];
        end
    end
`else
    always_comb begin
        scores_nx = '0;
        for (int k = 0; k < 8; k++)
            scores_nx[k*OUT_W +: OUT_W] = OUT_W'(acc[k] >>> SHIFT);
    end
`endif
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt      <= '0;
            scores_q <= '0;
            for (int k = 0; k < 8; k++)
                acc[k] <= '0;
        end else begin
            if (clr) begin
                cnt <= '0;
                for (int k = 0; k < 8; k++)
                    acc[k] <= '0;
            end else if (fire) begin
                cnt <= cnt + CW'(1);
                for (int k = 0; k < 8; k++)
                    acc[k] <= acc[k] + ACC_W'(prod[k]);
            end
            if (state == FINAL)
                scores_q <= scores_nx;
        end
    end
endmodule

// File: tb/tb_class_score_accumulator.sv
// tb_class_score_accumulator: directed checks of three accumulator configurations
module tb_class_score_accumulator;
    logic        Clk, Reset_n;
    logic [1:0]  sel;
    logic        start, in_valid;
    logic [7:0]  in_data;
    logic [63:0] w_data;
    logic        ready, busy, sv;
    logic [87:0] scores;
    int          n_chk, n_fail;
    int          wk[8];
    int          ex[8];

    class_score_accumulator_if #(.IN_W(8), .W_W(8), .OUT_W(11)) if_s ();
    class_score_accumulator_if #(.IN_W(8), .W_W(8), .OUT_W(11)) if_l ();
    class_score_accumulator_if #(.IN_W(8), .W_W(8), .OUT_W(11)) if_d ();

    class_score_accumulator #(.N_IN(4), .SHIFT(0)) dut_s (.Clk(Clk), .Reset_n(Reset_n), .bus(if_s));
    class_score_accumulator #(.N_IN(64), .SHIFT(0)) dut_l (.Clk(Clk), .Reset_n(Reset_n), .bus(if_l));
    class_score_accumulator dut_d (.Clk(Clk), .Reset_n(Reset_n), .bus(if_d));

    assign if_s.start    = start && sel == 2'd0;
    assign if_l.start    = start && sel == 2'd1;
    assign if_d.start    = start && sel == 2'd2;
    assign if_s.in_valid = in_valid && sel == 2'd0;
    assign if_l.in_valid = in_valid && sel == 2'd1;
    assign if_d.in_valid = in_valid && sel == 2'd2;
    assign if_s.in_data  = in_data;
    assign if_l.in_data  = in_data;
    assign if_d.in_data  = in_data;
    assign if_s.w_data   = w_data;
    assign if_l.w_data   = w_data;
    assign if_d.w_data   = w_data;
    assign ready  = sel == 2'd0 ? if_s.in_ready     : sel == 2'd1 ? if_l.in_ready     : if_d.in_ready;
    assign busy   = sel == 2'd0 ? if_s.busy         : sel == 2'd1 ? if_l.busy         : if_d.busy;
    assign sv     = sel == 2'd0 ? if_s.scores_valid : sel == 2'd1 ? if_l.scores_valid : if_d.scores_valid;
    assign scores = sel == 2'd0 ? if_s.scores       : sel == 2'd1 ? if_l.scores       : if_d.scores;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int score(input logic [87:0] v, input int k);
        logic signed [10:0] s;
        s = v[k*11 +: 11];
        return int'(s);
    endfunction

    function automatic int argmax(input logic [87:0] v);
        int best = 0;
        for (int k = 1; k < 8; k++)
            if (score(v, k) > score(v, best)) best = k;
        return best;
    endfunction

    function automatic logic [63:0] wv(input int w[8]);
        logic [63:0] r;
        int t;
        for (int k = 0; k < 8; k++) begin
            t = w[k];
            r[k*8 +: 8] = t[7:0];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic [63:0] w);
        in_data  = d;
        w_data   = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ready; i++) tick;
        if (!ready) check("ready_timeout", 0, 1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic chk_scores(input string tag, input int e[8]);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_score%0d", tag, k), score(scores, k), e[k]);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        Reset_n = 1'b0; sel = 2'd0; start = 1'b0; in_valid = 1'b0; in_data = '0; w_data = '0;
        #12;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_sv", sv, 0);
        check("rst_scores", scores, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        tick;
        check("idle_ready", ready, 0);

        // contiguous beats: score k = 4*k
        for (int k = 0; k < 8; k++) begin wk[k] = k; ex[k] = 4 * k; end
        do_start;
        check("t2_ready", ready, 1);
        check("t2_busy", busy, 1);
        for (int b = 0; b < 4; b++) beat(8'd1, wv(wk));
        check("t2_final_sv", sv, 0);
        check("t2_final_ready", ready, 0);
        check("t2_final_busy", busy, 1);
        tick;
        check("t2_done_sv", sv, 1);
        check("t2_done_busy", busy, 0);
        chk_scores("t2", ex);

        // stalled beats: 1,0,0,1,0,0,...
        do_start;
        check("t3_sv_cleared", sv, 0);
        for (int b = 0; b < 4; b++) begin
            beat(8'd1, wv(wk));
            if (b < 3) begin
                tick;
                check($sformatf("t3_stall_busy%0d", b), busy, 1);
                tick;
                check($sformatf("t3_stall_ready%0d", b), ready, 1);
            end
        end
        check("t3_final_ready", ready, 0);
        tick;
        check("t3_sv", sv, 1);
        chk_scores("t3", ex);

        // start in ACCUM ignored; start in DONE restarts with old scores held
        do_start;
        beat(8'd1, wv(wk));
        beat(8'd1, wv(wk));
        do_start;
        check("t5_accum_start_ready", ready, 1);
        beat(8'd1, wv(wk));
        beat(8'd1, wv(wk));
        check("t5_accum_start_final", busy && !ready, 1);
        tick;
        check("t5_sv", sv, 1);
        chk_scores("t5a", ex);
        do_start;
        check("t5_restart_sv", sv, 0);
        check("t5_restart_busy", busy, 1);
        check("t5_old_score7", score(scores, 7), 28);
        for (int b = 0; b < 4; b++) beat(8'd2, wv(wk));
        check("t5_final_old_score7", score(scores, 7), 28);
        tick;
        check("t5_new_sv", sv, 1);
        for (int k = 0; k < 8; k++) ex[k] = 8 * k;
        chk_scores("t5b", ex);

        // argmax: class 5 -> 300, others <= 100
        wk = '{-1, 1, 0, 1, -2, 3, 1, 0};
        for (int k = 0; k < 8; k++) ex[k] = 100 * wk[k];
        do_start;
        for (int b = 0; b < 4; b++) beat(8'd25, wv(wk));
        tick;
        chk_scores("t6", ex);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t6_sv%0d", c), sv, 1);
            check($sformatf("t6_argmax%0d", c), argmax(scores), 5);
            tick;
        end

        // large products: saturation vs wrap
        sel = 2'd1;
        do_start;
        for (int b = 0; b < 64; b++) beat(8'd127, 64'h7f7f7f7f7f7f7f7f);
        tick;
        check("t4_pos_sv", sv, 1);
`ifdef SCORE_SAT_EN
        for (int k = 0; k < 8; k++) ex[k] = 1023;
`else
        for (int k = 0; k < 8; k++) ex[k] = 64;
`endif
        chk_scores("t4_pos", ex);
        do_start;
        for (int b = 0; b < 64; b++) beat(8'd127, 64'h8080808080808080);
        tick;
        check("t4_neg_sv", sv, 1);
`ifdef SCORE_SAT_EN
        for (int k = 0; k < 8; k++) ex[k] = -1024;
`else
        for (int k = 0; k < 8; k++) ex[k] = 0;
`endif
        chk_scores("t4_neg", ex);

        // async reset mid-inference, then clean result with SHIFT=4
        sel = 2'd2;
        do_start;
        for (int b = 0; b < 10; b++) beat(8'd5, 64'h0102030405060708);
        check("t1_pre_busy", busy, 1);
        Reset_n = 1'b0;
        #1;
        check("t1_ready", ready, 0);
        check("t1_busy", busy, 0);
        check("t1_sv", sv, 0);
        check("t1_scores", scores, 0);
        check("t1_scores_l", if_l.scores, 0);
        check("t1_scores_s", if_s.scores, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        tick;
        check("t1_idle_ready", ready, 0);
        for (int k = 0; k < 8; k++) begin wk[k] = k - 4; ex[k] = 64 * (k - 4); end
        do_start;
        for (int b = 0; b < 64; b++) beat(8'd16, wv(wk));
        tick;
        check("t1_sv_after", sv, 1);
        chk_scores("t1", ex);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
